dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the data memory block (two 256×32 banks, 1-cycle read latency, active-low chip enable driven from its `stall` input). It shares the single memory port between the core load/store unit (port C) and the debug/program loader (port D). It issues one access per cycle, tracks the outstanding read owner, and routes the returned word back with a valid strobe. A starvation counter, or optional round-robin, bounds port D wait time.

---
 rtl/dmem_arbiter_pkg.sv | 33 +++
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/dmem_arb_pick.sv | 16 +
 rtl/syn_reg.sv | 18 +
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: op-code encodings,
// the load/store bit position, default starvation limit and the
// access bundle that is muxed onto the memory port.
package dmem_arbiter_pkg;

  // Memory op codes; bit2 set marks a load
  localparam logic [2:0] OP_SB  = 3'b000;
  localparam logic [2:0] OP_SH  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b100;
  localparam logic [2:0] OP_LH  = 3'b101;
  localparam logic [2:0] OP_LW  = 3'b110;
  localparam logic [2:0] OP_LBU = 3'b111;

  localparam int LS_BIT = 2;

  // Default cycles port D may wait before it is force-granted
  localparam int DMEM_ARB_STARVE_MAX = 15;

  typedef struct packed {
    logic [2:0]  op;
    logic [10:0] addr;
    logic [31:0] wdata;
  } arb_acc_t;

  // Idle memory port: load-type op so nothing can be written
  localparam arb_acc_t IDLE_ACC = '{op: OP_LB, addr: 11'd0, wdata: 32'd0};

  function automatic logic is_load(input logic [2:0] op);
    return op[LS_BIT];
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports C and D plus the shared memory port, bundled.
// slave: arbiter side. master: requesters + memory side.
interface dmem_arbiter_if;
  logic        c_req;
  logic [2:0]  c_op;
  logic [10:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_gnt;
  logic        c_rvalid;
  logic [31:0] c_rdata;

  logic        d_req;
  logic [2:0]  d_op;
  logic [10:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_stall;
  logic [2:0]  mem_op;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  c_req, c_op, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_op, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_stall, mem_op, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c_req, c_op, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_op, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_stall, mem_op, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between ports C and D.
// prio_d flips the tie-break toward D (starvation limit hit, or
// round-robin pointer says C went last).
module dmem_arb_pick (
  input  logic c_req,
  input  logic d_req,
  input  logic prio_d,
  output logic sel_c,
  output logic sel_d
);

  // D wins when alone or when it holds priority; otherwise C
  assign sel_d = d_req & (~c_req | prio_d);
  assign sel_c = c_req & ~sel_d;

endmodule

// File: rtl/syn_reg.sv
// Generic flop bank with asynchronous active-low reset to RST_VAL.
module syn_reg #(
  parameter int          W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Plain register, cleared asynchronously
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) q <= RST_VAL;
    else       q <= d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the data memory.
// One access per cycle, 0-cycle grant, load data returned one cycle
// after grant with a per-port valid strobe.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration;
// undefined gives fixed C priority with a port-D starvation counter.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DMEM_ARB_STARVE_MAX
) (
  input logic           clk,
  input logic           nrst,
  dmem_arbiter_if.slave bus
);

  logic     c_req_v, d_req_v;
  logic     prio_d, sel_c, sel_d;
  logic     rd_own_c, rd_own_d;
  arb_acc_t c_acc, d_acc, win;

  // No grants while reset is asserted
  assign c_req_v = bus.c_req & nrst;
  assign d_req_v = bus.d_req & nrst;

`ifdef DMEM_ARB_RR_EN
  logic last_c;

  // Round-robin pointer: remembers which port won the last grant;
  // reset value says C went last so D is preferred first
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)              last_c <= 1'b1;
    else if (sel_c | sel_d) last_c <= sel_c;
  end

  assign prio_d = last_c;
`else
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  logic [7:0] wait_cnt;

  // Count cycles D is kept waiting; saturate at the limit, clear
  // once D is served or stops asking
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                        wait_cnt <= 8'd0;
    else if (!bus.d_req || sel_d)     wait_cnt <= 8'd0;
    else if (wait_cnt != STARVE_LIM)  wait_cnt <= wait_cnt + 8'd1;
  end

  assign prio_d = (wait_cnt == STARVE_LIM);
`endif

  dmem_arb_pick u_pick (
    .c_req  (c_req_v),
    .d_req  (d_req_v),
    .prio_d (prio_d),
    .sel_c  (sel_c),
    .sel_d  (sel_d)
  );

  assign c_acc = '{op: bus.c_op, addr: bus.c_addr, wdata: bus.c_wdata};
  assign d_acc = '{op: bus.d_op, addr: bus.d_addr, wdata: bus.d_wdata};

  // Steer the winning access onto the memory port, idle pattern otherwise
  always_comb begin
    win = IDLE_ACC;
    if (sel_c)      win = c_acc;
    else if (sel_d) win = d_acc;
  end

  assign bus.mem_stall = ~(sel_c | sel_d);
  assign bus.mem_op    = win.op;
  assign bus.mem_addr  = win.addr;
  assign bus.mem_wdata = win.wdata;
  assign bus.c_gnt     = sel_c;
  assign bus.d_gnt     = sel_d;

  // Read ownership: a granted load makes its port the owner of the
  // word returned next cycle; stores never own a response
  syn_reg #(.W(1)) u_own_c (
    .clk  (clk),
    .nrst (nrst),
    .d    (sel_c & is_load(bus.c_op)),
    .q    (rd_own_c)
  );

  syn_reg #(.W(1)) u_own_d (
    .clk  (clk),
    .nrst (nrst),
    .d    (sel_d & is_load(bus.d_op)),
    .q    (rd_own_d)
  );

  assign bus.c_rvalid = rd_own_c;
  assign bus.d_rvalid = rd_own_d;
  assign bus.c_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory model, behavioural
// reference checked every cycle on the falling edge, directed
// scenarios with literal expectations, then random traffic.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int SM = 3;

  logic clk = 1'b0;
  logic nrst;
  int   n_chk = 0;
  int   n_err = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory model (2 KB, little endian) ----------------
  logic [7:0] mem [2048];

  function automatic logic [31:0] ld_val(input logic [10:0] a, input logic [2:0] op);
    logic [10:0] a1, a2, a3;
    a1 = a + 11'd1; a2 = a + 11'd2; a3 = a + 11'd3;
    case (op)
      OP_LB:   return {{24{mem[a][7]}}, mem[a]};
      OP_LBU:  return {24'd0, mem[a]};
      OP_LH:   return {{16{mem[a1][7]}}, mem[a1], mem[a]};
      default: return {mem[a3], mem[a2], mem[a1], mem[a]};
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    bus.mem_rdata = 32'd0;
  end

  always @(posedge clk) begin
    if (!bus.mem_stall) begin
      if (bus.mem_op[2]) bus.mem_rdata <= ld_val(bus.mem_addr, bus.mem_op);
      else begin
        mem[bus.mem_addr] <= bus.mem_wdata[7:0];
        if (bus.mem_op[1:0] != 2'b00) mem[bus.mem_addr + 11'd1] <= bus.mem_wdata[15:8];
        if (bus.mem_op[1:0] == 2'b10) begin
          mem[bus.mem_addr + 11'd2] <= bus.mem_wdata[23:16];
          mem[bus.mem_addr + 11'd3] <= bus.mem_wdata[31:24];
        end
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit          m_rv_c, m_rv_d, m_last_c;
  int          m_wait;
  logic [31:0] m_dat;

  always @(negedge clk) begin
    bit          pd, ew_c, ew_d;
    logic [2:0]  eop;
    logic [10:0] ead;
    logic [31:0] ewd;
    if (!nrst) begin
      chk("rst_gnt",    {30'd0, bus.c_gnt, bus.d_gnt}, 32'd0);
      chk("rst_stall",  {31'd0, bus.mem_stall}, 32'd1);
      chk("rst_rvalid", {30'd0, bus.c_rvalid, bus.d_rvalid}, 32'd0);
      m_rv_c = 0; m_rv_d = 0; m_wait = 0; m_last_c = 1;
    end else begin
`ifdef DMEM_ARB_RR_EN
      pd = m_last_c;
`else
      pd = (m_wait == SM);
`endif
      ew_d = bus.d_req && (!bus.c_req || pd);
      ew_c = bus.c_req && !ew_d;
      eop = OP_LB; ead = '0; ewd = '0;
      if (ew_c)      begin eop = bus.c_op; ead = bus.c_addr; ewd = bus.c_wdata; end
      else if (ew_d) begin eop = bus.d_op; ead = bus.d_addr; ewd = bus.d_wdata; end
      chk("c_gnt",     {31'd0, bus.c_gnt}, {31'd0, ew_c});
      chk("d_gnt",     {31'd0, bus.d_gnt}, {31'd0, ew_d});
      chk("mem_stall", {31'd0, bus.mem_stall}, {31'd0, !(ew_c || ew_d)});
      chk("mem_op",    {29'd0, bus.mem_op}, {29'd0, eop});
      chk("mem_addr",  {21'd0, bus.mem_addr}, {21'd0, ead});
      chk("mem_wdata", bus.mem_wdata, ewd);
      chk("c_rvalid",  {31'd0, bus.c_rvalid}, {31'd0, m_rv_c});
      chk("d_rvalid",  {31'd0, bus.d_rvalid}, {31'd0, m_rv_d});
      if (m_rv_c) chk("c_rdata", bus.c_rdata, m_dat);
      if (m_rv_d) chk("d_rdata", bus.d_rdata, m_dat);
      // next-cycle expectations
      m_rv_c = ew_c && eop[2];
      m_rv_d = ew_d && eop[2];
      if (eop[2]) m_dat = ld_val(ead, eop);
      if (bus.d_req && !ew_d) m_wait = (m_wait < SM) ? m_wait + 1 : SM;
      else                    m_wait = 0;
      if (ew_c || ew_d) m_last_c = ew_c;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.c_req = 0; bus.c_op = OP_LB; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 0; bus.d_op = OP_LB; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic set_c(input logic [2:0] op, input logic [10:0] a, input logic [31:0] wd);
    bus.c_req = 1; bus.c_op = op; bus.c_addr = a; bus.c_wdata = wd;
  endtask

  task automatic set_d(input logic [2:0] op, input logic [10:0] a, input logic [31:0] wd);
    bus.d_req = 1; bus.d_op = op; bus.d_addr = a; bus.d_wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [2:0] rand_op();
    logic [2:0] ops [7];
    ops = '{OP_SB, OP_SH, OP_SW, OP_LB, OP_LH, OP_LW, OP_LBU};
    return ops[$urandom_range(0, 6)];
  endfunction

  function automatic logic [10:0] rand_addr(input logic [2:0] op);
    logic [10:0] a;
    a = 11'($urandom);
    if (op[1:0] == 2'b01) a[0] = 1'b0;
    if (op[1:0] == 2'b10) a[1:0] = 2'b00;
    return a;
  endfunction

  logic [7:0]  pat;
  logic [3:0]  pat4;
  logic [31:0] lb_exp [4];
  logic [7:0]  lb_byte [4];
  bit          cg, dg;
  logic [2:0]  op;

  initial begin
    nrst = 1'b0;
    idle();
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    nrst = 1'b1;

    // Both ports request loads continuously from reset release
    for (int i = 0; i < 8; i++) begin
      set_c(OP_LW, 11'h100 + 11'(4 * i), 32'd0);
      set_d(OP_LW, 11'h200 + 11'(4 * i), 32'd0);
      @(negedge clk); pat[i] = bus.d_gnt;
      tick();
    end
`ifdef DMEM_ARB_RR_EN
    chk("contention_pattern", {24'd0, pat}, 32'h55);
`else
    chk("contention_pattern", {24'd0, pat}, 32'h88);
`endif
    idle(); tick(); tick();

    // C store word then load word
    set_c(OP_SW, 11'h004, 32'hDEADBEEF); tick();
    set_c(OP_LW, 11'h004, 32'd0);
    @(negedge clk); chk("lw_gnt_same_cycle", {31'd0, bus.c_gnt}, 32'd1);
    tick(); idle();
    @(negedge clk);
    chk("lw_rvalid", {31'd0, bus.c_rvalid}, 32'd1);
    chk("lw_rdata", bus.c_rdata, 32'hDEADBEEF);
    chk("lw_d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
    tick();

    // D writes bytes into bank 1, then C loads them back to back
    lb_byte = '{8'h80, 8'h01, 8'h7F, 8'hFF};
    lb_exp  = '{32'hFFFFFF80, 32'h00000001, 32'h0000007F, 32'hFFFFFFFF};
    for (int k = 0; k < 4; k++) begin
      set_d(OP_SB, 11'h400 + 11'(k), {24'd0, lb_byte[k]});
      tick();
    end
    idle();
    set_c(OP_LB, 11'h400, 32'd0); tick();
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) set_c(OP_LB, 11'h400 + 11'(k), 32'd0);
      else idle();
      @(negedge clk);
      chk("lb_rvalid", {31'd0, bus.c_rvalid}, 32'd1);
      chk("lb_rdata", bus.c_rdata, lb_exp[k-1]);
      tick();
    end

    // D store halfword: no response; C reads it back
    set_d(OP_SH, 11'h006, 32'h00001234);
    @(negedge clk); chk("sh_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
    tick(); idle();
    @(negedge clk); chk("sh_no_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
    tick();
    set_c(OP_LH, 11'h006, 32'd0); tick(); idle();
    @(negedge clk);
    chk("lh_rvalid", {31'd0, bus.c_rvalid}, 32'd1);
    chk("lh_rdata", bus.c_rdata, 32'h00001234);
    tick();

    // Random traffic; C holds until granted, D may withdraw
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); cg = bus.c_gnt; dg = bus.d_gnt;
      tick();
      if (!bus.c_req || cg) begin
        op = rand_op();
        bus.c_req = ($urandom_range(0, 3) != 0); bus.c_op = op;
        bus.c_addr = rand_addr(op); bus.c_wdata = $urandom;
      end
      if (!bus.d_req || dg) begin
        op = rand_op();
        bus.d_req = ($urandom_range(0, 2) != 0); bus.d_op = op;
        bus.d_addr = rand_addr(op); bus.d_wdata = $urandom;
      end else if ($urandom_range(0, 7) == 0) bus.d_req = 0;
    end
    idle(); tick(); tick();

    // Reset in the cycle after a C load grant
    set_c(OP_LW, 11'h004, 32'd0); tick();
    nrst = 1'b0;
    set_d(OP_LW, 11'h008, 32'd0);
    @(negedge clk);
    chk("rst_mid_c_rvalid", {31'd0, bus.c_rvalid}, 32'd0);
    chk("rst_mid_stall", {31'd0, bus.mem_stall}, 32'd1);
    chk("rst_mid_c_gnt", {31'd0, bus.c_gnt}, 32'd0);
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) chk("post_rst_c_rvalid", {31'd0, bus.c_rvalid}, 32'd0);
      pat4[i] = bus.d_gnt;
      tick();
    end
`ifdef DMEM_ARB_RR_EN
    chk("post_rst_pattern", {28'd0, pat4}, 32'h5);
`else
    chk("post_rst_pattern", {28'd0, pat4}, 32'h8);
`endif
    idle(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
